// File: rtl/lc3b_gshare_predictor_if.sv
// Fetch-side prediction and memory-stage resolution bundle for the gshare
// predictor, plus the statistics counters it exports.
//
// Handshake: there is no backpressure. pred_valid and upd_valid are single
// qualifiers sampled on every rising clk edge; ready is implicitly always 1.
// pred_taken/pred_index/pred_ghr are combinational and meaningful every cycle,
// whether or not pred_valid is high.
interface lc3b_gshare_predictor_if #(
  parameter int HIST_BITS  = 12,
  parameter int INDEX_BITS = 12
);
  logic                  pred_valid;
  logic [15:0]           pred_pc;
  logic                  pred_taken;
  logic [INDEX_BITS-1:0] pred_index;
  logic [HIST_BITS-1:0]  pred_ghr;
  logic                  upd_valid;
  logic [INDEX_BITS-1:0] upd_index;
  logic [HIST_BITS-1:0]  upd_ghr;
  logic                  upd_taken;
  logic                  upd_mispredict;
  logic [15:0]           stat_lookups;
  logic [15:0]           stat_mispredicts;

  modport master (
    output pred_valid, pred_pc, upd_valid, upd_index, upd_ghr, upd_taken, upd_mispredict,
    input  pred_taken, pred_index, pred_ghr, stat_lookups, stat_mispredicts
  );

  modport slave (
    input  pred_valid, pred_pc, upd_valid, upd_index, upd_ghr, upd_taken, upd_mispredict,
    output pred_taken, pred_index, pred_ghr, stat_lookups, stat_mispredicts
  );
endinterface

// File: rtl/lc3b_gshare_predictor.sv
// Gshare direction predictor: global history XOR fetch-PC bits indexes a
// table of saturating counters. Lookup is combinational; training and
// history repair happen on the resolution port one cycle later.
module lc3b_gshare_predictor #(
  parameter int HIST_BITS  = 12,
  parameter int INDEX_BITS = 12,
  parameter int CTR_BITS   = 2,
  parameter int PC_LSB     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lc3b_gshare_predictor_if.slave bp
);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [CTR_BITS-1:0]   ctr [DEPTH];
  logic [HIST_BITS-1:0]  ghr;
  logic [HIST_BITS-1:0]  ghr_spec;
  logic [HIST_BITS-1:0]  ghr_recov;
  logic [INDEX_BITS-1:0] index;
  logic                  recover;
  logic                  unused_pc_bits;

  // Only the PC window selected by PC_LSB/INDEX_BITS feeds the hash.
  assign unused_pc_bits = ^bp.pred_pc;

  assign index          = bp.pred_pc[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(ghr);
  assign bp.pred_index  = index;
  assign bp.pred_ghr    = ghr;
  // Reads the pre-update counter; a same-cycle write is seen next cycle.
  assign bp.pred_taken  = ctr[index][CTR_BITS-1];
  assign recover        = bp.upd_valid && bp.upd_mispredict;

  // Next history values; a 1-bit history simply holds the latest outcome.
  generate
    if (HIST_BITS == 1) begin : g_hist_one
      assign ghr_spec  = bp.pred_taken;
      assign ghr_recov = bp.upd_taken;
    end else begin : g_hist_many
      assign ghr_spec  = {ghr[HIST_BITS-2:0], bp.pred_taken};
      assign ghr_recov = {bp.upd_ghr[HIST_BITS-2:0], bp.upd_taken};
    end
  endgenerate

  // Counter table training: saturating increment on taken, decrement otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= CTR_INIT;
    end else if (bp.upd_valid) begin
      if (bp.upd_taken) begin
        if (ctr[bp.upd_index] != CTR_MAX) ctr[bp.upd_index] <= ctr[bp.upd_index] + 1'b1;
      end else begin
        if (ctr[bp.upd_index] != '0) ctr[bp.upd_index] <= ctr[bp.upd_index] - 1'b1;
      end
    end
  end

  // Global history: mispredict repair wins over the squashed same-cycle fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (recover) begin
      ghr <= ghr_recov;
    end else if (bp.pred_valid) begin
      ghr <= ghr_spec;
    end
  end

  // Statistics counters, saturating at 0xFFFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp.stat_lookups     <= '0;
      bp.stat_mispredicts <= '0;
    end else begin
      if (bp.pred_valid && bp.stat_lookups != 16'hFFFF)
        bp.stat_lookups <= bp.stat_lookups + 16'd1;
      if (recover && bp.stat_mispredicts != 16'hFFFF)
        bp.stat_mispredicts <= bp.stat_mispredicts + 16'd1;
    end
  end
endmodule

// File: tb/tb_lc3b_gshare_predictor.sv
// Bench for lc3b_gshare_predictor: directed steps plus randomized traffic
// checked against an integer reference model of the predictor.
module tb_lc3b_gshare_predictor;
  localparam int H     = 12;
  localparam int I     = 12;
  localparam int C     = 2;
  localparam int L     = 1;
  localparam int DEPTH = 1 << I;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lc3b_gshare_predictor_if #(.HIST_BITS(H), .INDEX_BITS(I)) bus ();
  lc3b_gshare_predictor_if #(.HIST_BITS(4), .INDEX_BITS(6)) bus2 ();

  lc3b_gshare_predictor #(.HIST_BITS(H), .INDEX_BITS(I), .CTR_BITS(C), .PC_LSB(L)) dut (
    .clk(clk), .rst_n(rst_n), .bp(bus)
  );
  lc3b_gshare_predictor #(.HIST_BITS(4), .INDEX_BITS(6), .CTR_BITS(3), .PC_LSB(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bp(bus2)
  );

  int total = 0;
  int bad   = 0;

  // reference model state (plain integers)
  int m_ctr [DEPTH];
  int m_ghr;
  int m_look;
  int m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int m_index(input int pc);
    return ((pc >> L) % DEPTH) ^ m_ghr;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_ctr[i] = (1 << (C - 1)) - 1;
    m_ghr  = 0;
    m_look = 0;
    m_mis  = 0;
  endtask

  // Advance the model by one clock using the inputs currently on the bus.
  task automatic m_clock();
    int pi, pt, ui;
    pi = m_index(int'(bus.pred_pc));
    pt = (m_ctr[pi] >= (1 << (C - 1))) ? 1 : 0;
    ui = int'(bus.upd_index);
    if (bus.upd_valid) begin
      if (bus.upd_taken) m_ctr[ui] = (m_ctr[ui] + 1 > (1 << C) - 1) ? (1 << C) - 1 : m_ctr[ui] + 1;
      else               m_ctr[ui] = (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
    end
    if (bus.upd_valid && bus.upd_mispredict)
      m_ghr = (int'(bus.upd_ghr) * 2 + int'(bus.upd_taken)) % (1 << H);
    else if (bus.pred_valid)
      m_ghr = (m_ghr * 2 + pt) % (1 << H);
    if (bus.pred_valid && m_look < 65535) m_look++;
    if (bus.upd_valid && bus.upd_mispredict && m_mis < 65535) m_mis++;
  endtask

  task automatic check_all(input string tag);
    int pi;
    pi = m_index(int'(bus.pred_pc));
    chk({tag, ".index"}, 32'(bus.pred_index), 32'(pi));
    chk({tag, ".taken"}, 32'(bus.pred_taken), (m_ctr[pi] >= (1 << (C - 1))) ? 32'd1 : 32'd0);
    chk({tag, ".ghr"},   32'(bus.pred_ghr), 32'(m_ghr));
    chk({tag, ".look"},  32'(bus.stat_lookups), 32'(m_look));
    chk({tag, ".mis"},   32'(bus.stat_mispredicts), 32'(m_mis));
  endtask

  // driver: one clock with model check at the falling edge
  task automatic cycle(input string tag);
    @(negedge clk);
    check_all(tag);
    m_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pred_valid     = 1'b0;
    bus.upd_valid      = 1'b0;
    bus.upd_index      = '0;
    bus.upd_ghr        = '0;
    bus.upd_taken      = 1'b0;
    bus.upd_mispredict = 1'b0;
  endtask

  task automatic idle2();
    bus2.pred_valid     = 1'b0;
    bus2.pred_pc        = 16'h0010;
    bus2.upd_valid      = 1'b0;
    bus2.upd_index      = '0;
    bus2.upd_ghr        = '0;
    bus2.upd_taken      = 1'b0;
    bus2.upd_mispredict = 1'b0;
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    idle2();
    bus.pred_pc = 16'h3000;
    m_reset();
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // reset state
    @(negedge clk);
    chk("rst.index", 32'(bus.pred_index), 32'h800);
    chk("rst.taken", 32'(bus.pred_taken), 32'd0);
    chk("rst.ghr",   32'(bus.pred_ghr), 32'h000);
    chk("rst.look",  32'(bus.stat_lookups), 32'd0);
    chk("rst.mis",   32'(bus.stat_mispredicts), 32'd0);
    @(posedge clk);
    #1;

    // three lookups with a not-taken prediction shift zeros
    bus.pred_valid = 1'b1;
    for (int i = 0; i < 3; i++) cycle("look3");
    bus.pred_valid = 1'b0;
    chk("look3.ghr",  32'(bus.pred_ghr), 32'h000);
    chk("look3.stat", 32'(bus.stat_lookups), 32'd3);

    // train up at 0x800: 01->10->11->11
    bus.upd_valid = 1'b1; bus.upd_index = 12'h800; bus.upd_taken = 1'b1;
    cycle("train_up1");
    chk("train_up1.taken", 32'(bus.pred_taken), 32'd1);
    cycle("train_up2");
    cycle("train_up3");
    // train down: 11->10->01->00->00
    bus.upd_taken = 1'b0;
    cycle("train_dn1");
    chk("train_dn1.taken", 32'(bus.pred_taken), 32'd1);
    cycle("train_dn2");
    chk("train_dn2.taken", 32'(bus.pred_taken), 32'd0);
    cycle("train_dn3");
    cycle("train_dn4");
    idle();

    // recovery sets ghr to 0x00F, then recovery beats a same-cycle lookup
    bus.upd_valid = 1'b1; bus.upd_mispredict = 1'b1; bus.upd_index = 12'h123;
    bus.upd_ghr = 12'h007; bus.upd_taken = 1'b1;
    cycle("recov_a");
    chk("recov_a.ghr", 32'(bus.pred_ghr), 32'h00F);
    bus.pred_valid = 1'b1; bus.upd_ghr = 12'h123;
    cycle("recov_b");
    chk("recov_b.ghr", 32'(bus.pred_ghr), 32'h247);
    idle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bus.pred_valid     = 1'($urandom_range(0, 1));
      bus.pred_pc        = 16'h3000 + 16'($urandom_range(0, 15) * 2);
      bus.upd_valid      = ($urandom_range(0, 3) != 0);
      bus.upd_index      = ($urandom_range(0, 1) == 1) ? 12'(m_index(int'(bus.pred_pc)))
                                                       : 12'($urandom_range(0, DEPTH - 1));
      bus.upd_taken      = 1'($urandom_range(0, 1));
      bus.upd_mispredict = ($urandom_range(0, 7) == 0);
      bus.upd_ghr        = 12'($urandom_range(0, (1 << H) - 1));
      cycle("rand");
    end

    // asynchronous reset mid-operation with an update pending
    bus.upd_valid = 1'b1; bus.upd_taken = 1'b1; bus.upd_mispredict = 1'b1;
    bus.upd_index = 12'h800; bus.upd_ghr = 12'hABC; bus.pred_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("midrst.ghr",  32'(bus.pred_ghr), 32'h000);
    chk("midrst.look", 32'(bus.stat_lookups), 32'd0);
    chk("midrst.mis",  32'(bus.stat_mispredicts), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    bus.pred_pc = 16'h3000;
    cycle("post_rst");
    for (int n = 0; n < 40; n++) begin
      bus.pred_valid     = 1'($urandom_range(0, 1));
      bus.pred_pc        = 16'($urandom_range(0, 65535));
      bus.upd_valid      = 1'($urandom_range(0, 1));
      bus.upd_index      = 12'(m_index(int'(bus.pred_pc)));
      bus.upd_taken      = 1'($urandom_range(0, 1));
      bus.upd_mispredict = 1'($urandom_range(0, 1));
      bus.upd_ghr        = 12'($urandom_range(0, (1 << H) - 1));
      cycle("rand2");
    end
    idle();

    // small configuration: HIST=4, INDEX=6, CTR=3
    bus2.upd_valid = 1'b1; bus2.upd_mispredict = 1'b1; bus2.upd_ghr = 4'h2;
    bus2.upd_taken = 1'b1; bus2.upd_index = 6'h00;
    @(posedge clk);
    #1;
    idle2();
    chk("p2.ghr",   32'(bus2.pred_ghr), 32'h5);
    chk("p2.index", 32'(bus2.pred_index), 32'h0D);
    chk("p2.taken_init", 32'(bus2.pred_taken), 32'd0);
    bus2.upd_valid = 1'b1; bus2.upd_taken = 1'b1; bus2.upd_index = 6'h0D;
    @(posedge clk);
    #1;
    idle2();
    chk("p2.taken_after1", 32'(bus2.pred_taken), 32'd1);
    chk("p2.mis1", 32'(bus2.stat_mispredicts), 32'd1);

    // mispredict counter saturation
    bus2.upd_valid = 1'b1; bus2.upd_mispredict = 1'b1;
    for (int n = 0; n < 65533; n++) begin
      bus2.upd_taken = 1'($urandom_range(0, 1));
      bus2.upd_index = 6'($urandom_range(0, 63));
      @(posedge clk);
    end
    #1;
    chk("p2.mis_65534", 32'(bus2.stat_mispredicts), 32'd65534);
    @(posedge clk);
    #1;
    chk("p2.mis_sat", 32'(bus2.stat_mispredicts), 32'hFFFF);
    for (int n = 0; n < 5; n++) @(posedge clk);
    #1;
    chk("p2.mis_hold", 32'(bus2.stat_mispredicts), 32'hFFFF);
    idle2();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
